mult_issue_stage: RTL and testbench

- Sequential operand-issue and result-capture wrapper for the combinational WIDTHxWIDTH unsigned array multiplier (4x4 -> 8).
- Accepts operands over a valid/ready handshake and registers them.
- Drives the multiplier from those registers, then registers the returned product on a backpressured output port.
- Adds signed mode by sign-magnitude conversion around the unsigned multiplier. Sits between the multdiv control path and the multiplier core.

---
 rtl/mult_issue_stage.sv | 108 ++++++++++
 tb/tb_mult_issue_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue_stage.sv
// Two-stage operand-issue / result-capture wrapper around an external unsigned
// WIDTHxWIDTH multiplier core, with signed mode via sign-magnitude conversion.

module mult_issue_mag #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] opnd,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);
  // The most-negative operand negates to itself, which is the correct unsigned magnitude.
  assign neg = is_signed & opnd[WIDTH-1];
  assign mag = neg ? ((~opnd) + WIDTH'(1)) : opnd;
endmodule

module mult_issue_stage #(
  parameter int WIDTH = 4,
  parameter int TAG_W = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [WIDTH-1:0]   mult_a,
  output logic [WIDTH-1:0]   mult_b,
  input  logic [2*WIDTH-1:0] mult_p,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);
  localparam int NOPS   = 2;
  localparam int STAGES = 2;

  logic [NOPS-1:0][WIDTH-1:0] opnd;
  logic [NOPS-1:0][WIDTH-1:0] opnd_mag;
  logic [NOPS-1:0]            opnd_neg;

  logic [STAGES:1]   vld_q;
  logic [STAGES:0]   vld_pipe;
  logic [WIDTH-1:0]  s1_amag, s1_bmag;
  logic              s1_neg;
  logic [TAG_W-1:0]  s1_tag;
  logic              s2_free, adv, accept;
  logic [2*WIDTH-1:0] p_signed;

  assign opnd = {in_b, in_a};

  for (genvar i = 0; i < NOPS; i++) begin : g_mag
    mult_issue_mag #(.WIDTH(WIDTH)) u_mag (
      .opnd      (opnd[i]),
      .is_signed (in_signed),
      .mag       (opnd_mag[i]),
      .neg       (opnd_neg[i])
    );
  end

  // vld_pipe[0] is the accept strobe; [1] issue register, [2] result register.
  assign vld_pipe  = {vld_q, accept};
  assign s2_free   = ~vld_pipe[2] | out_ready;
  assign adv       = vld_pipe[1] & s2_free;
  assign in_ready  = ~vld_pipe[1] | s2_free;
  assign accept    = in_valid & in_ready;

  assign mult_a    = s1_amag;
  assign mult_b    = s1_bmag;
  // Negating a zero product yields zero, so no negative-zero special case.
  assign p_signed  = s1_neg ? ((~mult_p) + (2*WIDTH)'(1)) : mult_p;

  assign out_valid = vld_pipe[2];
  assign busy      = vld_pipe[1] | vld_pipe[2];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      s1_amag <= '0;
      s1_bmag <= '0;
      s1_neg  <= 1'b0;
      s1_tag  <= '0;
      out_p   <= '0;
      out_tag <= '0;
    end else begin
      if (accept) begin
        vld_q[1] <= 1'b1;
        s1_amag  <= opnd_mag[0];
        s1_bmag  <= opnd_mag[1];
        s1_neg   <= opnd_neg[0] ^ opnd_neg[1];
        s1_tag   <= in_tag;
      end else if (adv) begin
        vld_q[1] <= 1'b0;
      end

      if (adv) begin
        vld_q[2] <= 1'b1;
        out_p    <= p_signed;
        out_tag  <= s1_tag;
      end else if (out_ready) begin
        vld_q[2] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mult_issue_stage.sv
// Bench for mult_issue_stage: behavioural multiplier core, table-driven single ops,
// scoreboard on every output handshake, and hand-written multi-cycle sequences.

module tb_mult_issue_stage;
  logic       clock, reset;
  logic       in_valid, in_ready, in_signed;
  logic [3:0] in_a, in_b, mult_a, mult_b;
  logic [2:0] in_tag, out_tag;
  logic [7:0] mult_p, out_p;
  logic       out_valid, out_ready, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] a, b;
    logic       s;
    logic [2:0] tag;
    logic [7:0] p;
    logic [3:0] ma, mb;
  } vec_t;

  typedef struct {
    logic [7:0] p;
    logic [2:0] tag;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];

  mult_issue_stage #(.WIDTH(4), .TAG_W(3)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_tag(out_tag), .busy(busy)
  );

  assign mult_p = {4'd0, mult_a} * {4'd0, mult_b};

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] model_p(input logic [3:0] a, input logic [3:0] b, input logic s);
    int ia, ib, pr;
    ia = (s && a[3]) ? int'(a) - 16 : int'(a);
    ib = (s && b[3]) ? int'(b) - 16 : int'(b);
    pr = ia * ib;
    return pr[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  always @(negedge clock) begin
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back('{model_p(in_a, in_b, in_signed), in_tag});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got result %0d tag %0d, expected none", out_p, out_tag);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_p", {24'd0, out_p}, {24'd0, e.p});
          check("sb_tag", {29'd0, out_tag}, {29'd0, e.tag});
        end
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [2:0] tag);
    int n = 0;
    in_a = a; in_b = b; in_signed = s; in_tag = tag; in_valid = 1;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      if (++n > 20) begin
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  vec_t vecs[6];
  logic [7:0] held_p;
  logic [2:0] held_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd15, 4'd15, 1'b0, 3'd5, 8'd225,  4'd15, 4'd15};
    vecs[1] = '{4'd8,  4'd7,  1'b1, 3'd1, 8'hC8,   4'd8,  4'd7};
    vecs[2] = '{4'd8,  4'd8,  1'b1, 3'd2, 8'h40,   4'd8,  4'd8};
    vecs[3] = '{4'd0,  4'd13, 1'b1, 3'd3, 8'd0,    4'd0,  4'd3};
    vecs[4] = '{4'd3,  4'd5,  1'b0, 3'd4, 8'd15,   4'd3,  4'd5};
    vecs[5] = '{4'd13, 4'd2,  1'b1, 3'd6, 8'hFA,   4'd3,  4'd2};

    reset = 1; in_valid = 0; in_a = 0; in_b = 0; in_signed = 0; in_tag = 0; out_ready = 1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_out_p", {24'd0, out_p}, 0);
    check("rst_mult_a", {28'd0, mult_a}, 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    check("idle_in_ready", {31'd0, in_ready}, 1);
    @(posedge clock); #1;

    foreach (vecs[i]) begin
      send(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag);
      @(negedge clock);
      check($sformatf("v%0d_mult_a", i), {28'd0, mult_a}, {28'd0, vecs[i].ma});
      check($sformatf("v%0d_mult_b", i), {28'd0, mult_b}, {28'd0, vecs[i].mb});
      check($sformatf("v%0d_early", i), {31'd0, out_valid}, 0);
      @(negedge clock);
      check($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 1);
      check($sformatf("v%0d_out_p", i), {24'd0, out_p}, {24'd0, vecs[i].p});
      check($sformatf("v%0d_out_tag", i), {29'd0, out_tag}, {29'd0, vecs[i].tag});
      @(posedge clock); #1;
    end

    // Back-to-back at full throughput.
    repeat (2) @(posedge clock); #1;
    pop_cyc.delete();
    send(4'd3, 4'd5, 1'b0, 3'd0);
    send(4'd2, 4'd6, 1'b0, 3'd1);
    send(4'd9, 4'd9, 1'b0, 3'd2);
    send(4'd0, 4'd13, 1'b0, 3'd3);
    repeat (4) @(posedge clock); #1;
    check("b2b_count", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) check("b2b_span", pop_cyc[3] - pop_cyc[0], 3);
    check("b2b_sb_empty", sb.size(), 0);

    // Backpressure: two accepted, third stalls until release.
    out_ready = 0;
    pop_cyc.delete();
    send(4'd7, 4'd3, 1'b0, 3'd4);
    send(4'd4, 4'd4, 1'b0, 3'd5);
    fork
      send(4'd6, 4'd2, 1'b0, 3'd6);
      begin
        @(negedge clock);
        check("bp_in_ready", {31'd0, in_ready}, 0);
        check("bp_out_p", {24'd0, out_p}, 21);
        held_p = out_p; held_t = out_tag;
        repeat (3) @(negedge clock);
        check("bp_hold_p", {24'd0, out_p}, {24'd0, held_p});
        check("bp_hold_tag", {29'd0, out_tag}, {29'd0, held_t});
        check("bp_hold_valid", {31'd0, out_valid}, 1);
        @(posedge clock); #1;
        out_ready = 1;
      end
    join
    repeat (4) @(posedge clock); #1;
    check("bp_drain_count", pop_cyc.size(), 3);
    check("bp_sb_empty", sb.size(), 0);

    // Reset with both stages full.
    out_ready = 0;
    send(4'd5, 4'd5, 1'b0, 3'd1);
    send(4'd6, 4'd6, 1'b0, 3'd2);
    @(negedge clock);
    check("full_busy", {31'd0, busy}, 1);
    check("full_in_ready", {31'd0, in_ready}, 0);
    #2 reset = 1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_out_p", {24'd0, out_p}, 0);
    sb.delete();
    @(posedge clock); #3;
    reset = 0;
    out_ready = 1;
    pop_cyc.delete();
    repeat (5) @(negedge clock);
    check("no_stale_count", pop_cyc.size(), 0);
    check("post_rst_out_valid", {31'd0, out_valid}, 0);
    check("post_rst_in_ready", {31'd0, in_ready}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
